// File: rtl/bf16_op_sched_if.sv
// op_intf: split bf16 operand/result bus between the scheduler and a shared compute unit
interface op_intf;
  logic       op1_sign;
  logic [7:0] op1_exp;
  logic [6:0] op1_frac;
  logic       op2_sign;
  logic [7:0] op2_exp;
  logic [6:0] op2_frac;
  logic       op3_sign;
  logic [7:0] op3_exp;
  logic [6:0] op3_frac;
  logic       overflow;
  modport bus_side (
    output op1_sign, op1_exp, op1_frac, op2_sign, op2_exp, op2_frac,
    input  op3_sign, op3_exp, op3_frac, overflow
  );
  modport unit_side (
    input  op1_sign, op1_exp, op1_frac, op2_sign, op2_exp, op2_frac,
    output op3_sign, op3_exp, op3_frac, overflow
  );
endinterface

// File: rtl/bf16_op_sched.sv
// bf16_op_sched: round-robin sharing of one bf16 compute unit; sticky overflow under BF16_SCHED_OVF_STICKY_EN
module bf16_op_sched #(
  parameter int N_REQ    = 2,
  parameter int COMP_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0][15:0] req_op1,
  input  logic [N_REQ-1:0][15:0] req_op2,
  output logic [N_REQ-1:0]       resp_valid,
  input  logic [N_REQ-1:0]       resp_ready,
  output logic [15:0]            resp_data,
  output logic                   resp_overflow,
  output logic                   ovf_sticky,
  input  logic                   ovf_clr,
  op_intf.bus_side               comp
);
  localparam int PW = $clog2(N_REQ);
  localparam int LW = $clog2(COMP_LAT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [PW-1:0] rr_ptr, grant, winner;
  logic [LW-1:0] lat_cnt;
  logic [15:0] op1_q, op2_q;
  logic found, accept, cap, done;
  int idx;
  // first valid requester at or after rr_ptr, wrapping around
  always_comb begin
    found = 1'b0;
    winner = '0;
    idx = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (!found && req_valid[PW'(idx)]) begin
        found = 1'b1;
        winner = PW'(idx);
      end
    end
  end
  assign accept = state == IDLE && found;
  assign cap = state == WAIT && lat_cnt == LW'(1);
  assign done = state == RESP && resp_ready[grant];
  assign req_ready = (!rst && accept) ? N_REQ'(1) << winner : '0;
  // next-state selection
  always_comb begin
    state_nx = state;
    state_nx = accept ? WAIT : cap ? RESP : done ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // operand capture, latency count, result capture and response handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      grant <= '0;
      lat_cnt <= '0;
      op1_q <= '0;
      op2_q <= '0;
      resp_data <= '0;
      resp_overflow <= 1'b0;
      resp_valid <= '0;
    end else begin
      if (accept) begin
        op1_q <= req_op1[winner];
        op2_q <= req_op2[winner];
        grant <= winner;
        lat_cnt <= LW'(COMP_LAT);
        rr_ptr <= (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
      end else if (state == WAIT) lat_cnt <= lat_cnt - 1'b1;
      if (cap) begin
        resp_data <= {comp.op3_sign, comp.op3_exp, comp.op3_frac};
        resp_overflow <= comp.overflow;
        resp_valid <= N_REQ'(1) << grant;
      end else if (done) resp_valid <= '0;
    end
  end
  assign {comp.op1_sign, comp.op1_exp, comp.op1_frac} = op1_q;
  assign {comp.op2_sign, comp.op2_exp, comp.op2_frac} = op2_q;
`ifdef BF16_SCHED_OVF_STICKY_EN
  // sticky overflow; a new overflow capture beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) ovf_sticky <= 1'b0;
    else if (cap && comp.overflow) ovf_sticky <= 1'b1;
    else if (ovf_clr) ovf_sticky <= 1'b0;
  end
`else
  logic unused_clr;
  assign unused_clr = ovf_clr;
  assign ovf_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_bf16_op_sched.sv
// tb_bf16_op_sched: directed checks of arbitration, latency, hold, overflow and reset abort
module tb_bf16_op_sched;
  localparam int N = 2;
`ifdef BF16_SCHED_OVF_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, ovf_clr, resp_overflow, ovf_sticky, stub_ovf;
  logic [N-1:0] req_valid, req_ready, resp_valid, resp_ready;
  logic [N-1:0][15:0] req_op1, req_op2;
  logic [15:0] resp_data, stub_res;
  logic b_rst, b_ovf_clr, b_resp_overflow, b_ovf_sticky;
  logic [N-1:0] b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
  logic [N-1:0][15:0] b_req_op1, b_req_op2;
  logic [15:0] b_resp_data;
  int n_chk = 0, n_err = 0;
  op_intf comp();
  op_intf b_comp();
  assign {comp.op3_sign, comp.op3_exp, comp.op3_frac} = stub_res;
  assign comp.overflow = stub_ovf;
  assign {b_comp.op3_sign, b_comp.op3_exp, b_comp.op3_frac} = 16'h1111;
  assign b_comp.overflow = 1'b0;
  bf16_op_sched #(.N_REQ(N), .COMP_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_overflow(resp_overflow), .ovf_sticky(ovf_sticky),
    .ovf_clr(ovf_clr), .comp(comp)
  );
  bf16_op_sched #(.N_REQ(N), .COMP_LAT(4)) dut_b (
    .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_op1(b_req_op1), .req_op2(b_req_op2), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_data(b_resp_data), .resp_overflow(b_resp_overflow), .ovf_sticky(b_ovf_sticky),
    .ovf_clr(b_ovf_clr), .comp(b_comp)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  initial begin
    int n, last, t;
    logic seen;
    rst = 1'b1; ovf_clr = 1'b0; req_valid = '1; resp_ready = '0;
    req_op1 = '0; req_op2 = '0; stub_res = 16'h0; stub_ovf = 1'b0;
    b_rst = 1'b1; b_ovf_clr = 1'b0; b_req_valid = '0; b_resp_ready = '1;
    b_req_op1[0] = 16'h0101; b_req_op1[1] = 16'h0202; b_req_op2 = '0;
    repeat (2) begin
      @(negedge clk); #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_data", resp_data, 0);
      chk("rst_flags", {resp_overflow, ovf_sticky}, 0);
      chk("rst_ops", {comp.op1_sign, comp.op1_exp, comp.op1_frac, comp.op2_sign, comp.op2_exp, comp.op2_frac}, 0);
    end
    rst = 1'b0; b_rst = 1'b0; #1;
    chk("first_grant", req_ready, 2'b01);
    req_valid = '0;
    @(negedge clk);
    req_valid = 2'b10; req_op1[1] = 16'h3F80; req_op2[1] = 16'h4000; stub_res = 16'h4040; #1;
    chk("single_ready", req_ready, 2'b10);
    @(negedge clk);
    req_valid = 2'b01; #1;
    chk("wait_no_ready", req_ready, 0);
    chk("op1_fields", {comp.op1_sign, comp.op1_exp, comp.op1_frac}, {1'b0, 8'h7F, 7'h0});
    chk("op2_word", {comp.op2_sign, comp.op2_exp, comp.op2_frac}, 16'h4000);
    chk("wait_no_resp", resp_valid, 0);
    @(negedge clk); #1;
    chk("single_resp_valid", resp_valid, 2'b10);
    chk("single_data", resp_data, 16'h4040);
    chk("resp_no_ready", req_ready, 0);
    req_valid = '0; resp_ready = 2'b10;
    @(negedge clk); #1;
    chk("single_done", resp_valid, 0);
    req_valid = 2'b11; resp_ready = 2'b11;
    n = 0; last = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      #1;
      if (|req_ready) begin
        chk($sformatf("rr_grant%0d", n), req_ready, (n % 2 == 0) ? 2'b01 : 2'b10);
        if (n > 0) chk("rr_gap", c - last, 3);
        last = c;
        n++;
      end
      @(negedge clk);
    end
    chk("rr_count", n, 6);
    req_valid = '0;
    repeat (3) @(negedge clk);
    resp_ready = '0; req_valid = 2'b01; stub_res = 16'h7F80; stub_ovf = 1'b1; #1;
    chk("ovf_ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    chk("ovf_resp", {resp_valid, resp_overflow, resp_data}, {2'b01, 1'b1, 16'h7F80});
    chk("sticky_set", ovf_sticky, STICKY);
    resp_ready = 2'b01; stub_ovf = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("sticky_hold", ovf_sticky, STICKY);
    chk("ovf_done", resp_valid, 0);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0; #1;
    chk("sticky_clr", ovf_sticky, 0);
    resp_ready = 2'b10; req_valid = 2'b01; req_op1[0] = 16'hC0A0; stub_res = 16'h1234; #1;
    chk("hold_ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b11;
    @(negedge clk);
    stub_res = 16'h5555;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("hold_data", resp_data, 16'h1234);
      chk("hold_no_ready", req_ready, 0);
      chk("hold_valid", resp_valid, 2'b01);
      @(negedge clk);
    end
    resp_ready = 2'b01; req_valid = 2'b10; req_op1[1] = 16'hBF80;
    @(negedge clk); #1;
    chk("after_hs_ready", req_ready, 2'b10);
    chk("after_hs_valid", resp_valid, 0);
    @(negedge clk); #1;
    chk("next_op1", {comp.op1_sign, comp.op1_exp, comp.op1_frac}, 16'hBF80);
    req_valid = '0; resp_ready = 2'b11;
    repeat (3) @(negedge clk);
    b_req_valid = 2'b01; #1;
    chk("b_ready", b_req_ready, 2'b01);
    t = 0;
    do begin
      @(negedge clk);
      b_req_valid = '0;
      t++;
      #1;
    end while (b_resp_valid == 0 && t < 20);
    chk("b_lat", t, 5);
    chk("b_data", b_resp_data, 16'h1111);
    @(negedge clk);
    b_req_valid = 2'b01; #1;
    chk("b_wrap", b_req_ready, 2'b01);
    @(negedge clk);
    b_req_valid = '0;
    @(negedge clk);
    b_rst = 1'b1;
    @(negedge clk);
    b_rst = 1'b0; #1;
    chk("b_ops_cleared", {b_comp.op1_sign, b_comp.op1_exp, b_comp.op1_frac}, 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk); #1;
      if (b_resp_valid != 0) seen = 1'b1;
    end
    chk("b_no_resp", seen, 0);
    b_req_valid = 2'b11; #1;
    chk("b_after_rst", b_req_ready, 2'b01);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
